// File: rtl/mcdf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mcdf_arbiter
// Purpose  : Shares one formatter datapath between three slave FIFO channels,
//            one packet at a time. The winner is the requester with the lowest
//            priority value. Ties are broken round-robin, starting after the
//            last granted slave. The winner's words are forwarded as a
//            registered stream and counted against its packet length. A
//            framing error is flagged if end arrives early or is missing.
// Ports    : clk_i, rst_i           clock, synchronous active-high reset
//            slvN_req_i             slave N has a complete packet ready
//            slvN_val_i/data_i/end_i  slave N word stream
//            slvN_prio_i            slave N priority (0 = highest)
//            slvN_pkglen_i          slave N length code (4/8/16/32 words)
//            fmt_rdy_i              formatter can take a whole packet
//            a2sN_ack_o             one-cycle grant pulse to slave N
//            arb_val_o/data_o/start_o/end_o  output word stream
//            arb_id_o, arb_len_o    source and length of current packet
//            arb_busy_o             packet in flight (ACK or XFER)
//            arb_err_o              one-cycle framing-error pulse
// Revision : 1.0  initial release
// ============================================================================
module mcdf_arbiter #(
  parameter int DW   = 32,
  parameter int NSLV = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv0_req_i,
  input  logic          slv1_req_i,
  input  logic          slv2_req_i,
  input  logic          slv0_val_i,
  input  logic          slv1_val_i,
  input  logic          slv2_val_i,
  input  logic [DW-1:0] slv0_data_i,
  input  logic [DW-1:0] slv1_data_i,
  input  logic [DW-1:0] slv2_data_i,
  input  logic          slv0_end_i,
  input  logic          slv1_end_i,
  input  logic          slv2_end_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    slv0_pkglen_i,
  input  logic [2:0]    slv1_pkglen_i,
  input  logic [2:0]    slv2_pkglen_i,
  input  logic          fmt_rdy_i,
  output logic          a2s0_ack_o,
  output logic          a2s1_ack_o,
  output logic          a2s2_ack_o,
  output logic          arb_val_o,
  output logic [DW-1:0] arb_data_o,
  output logic          arb_start_o,
  output logic          arb_end_o,
  output logic [1:0]    arb_id_o,
  output logic [5:0]    arb_len_o,
  output logic          arb_busy_o,
  output logic          arb_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_id;
  logic [5:0]      r_len;
  logic [5:0]      r_cnt;
  logic [2:0]      r_ack;
  logic            r_val;
  logic [DW-1:0]   r_data;
  logic            r_start;
  logic            r_end;
  logic            r_err;

  logic            w_req  [NSLV];
  logic [1:0]      w_prio [NSLV];
  logic [1:0]      w_code [NSLV];

  logic            w_any_req;
  logic [1:0]      w_win;
  logic [1:0]      w_win_code;
  logic [1:0]      w_best;
  logic [5:0]      w_win_len;

  logic            w_sel_val;
  logic [DW-1:0]   w_sel_data;
  logic            w_sel_end;
  logic            w_cnt_last;
  logic            w_term;
  logic            w_unused_pkglen;

  assign w_req[0]  = slv0_req_i;
  assign w_req[1]  = slv1_req_i;
  assign w_req[2]  = slv2_req_i;
  assign w_prio[0] = slv0_prio_i;
  assign w_prio[1] = slv1_prio_i;
  assign w_prio[2] = slv2_prio_i;
  assign w_code[0] = slv0_pkglen_i[1:0];
  assign w_code[1] = slv1_pkglen_i[1:0];
  assign w_code[2] = slv2_pkglen_i[1:0];

  // Bit 2 of the length code carries no meaning.
  assign w_unused_pkglen = slv0_pkglen_i[2] ^ slv1_pkglen_i[2] ^ slv2_pkglen_i[2];

  // Visit slaves in round-robin order starting after the last grant. A strict
  // less-than keeps the first-visited slave among equal lowest priorities.
  always_comb begin
    w_any_req  = 1'b0;
    w_win      = 2'd0;
    w_win_code = 2'd0;
    w_best     = 2'd3;
    for (int k = 0; k < NSLV; k++) begin
      logic [2:0] v_pos;
      v_pos = {1'b0, r_last} + 3'd1 + 3'(k);
      if (v_pos >= 3'd3) begin
        v_pos = v_pos - 3'd3;
      end
      if (w_req[v_pos[1:0]] && (!w_any_req || (w_prio[v_pos[1:0]] < w_best))) begin
        w_any_req  = 1'b1;
        w_best     = w_prio[v_pos[1:0]];
        w_win      = v_pos[1:0];
        w_win_code = w_code[v_pos[1:0]];
      end
    end
  end

  // Length codes 0..3 map to 4, 8, 16, 32 words.
  assign w_win_len = 6'd4 << w_win_code;

  // Only the granted slave's stream is observed during a transfer.
  always_comb begin
    w_sel_val  = 1'b0;
    w_sel_data = '0;
    w_sel_end  = 1'b0;
    case (r_id)
      2'd1: begin
        w_sel_val  = slv1_val_i;
        w_sel_data = slv1_data_i;
        w_sel_end  = slv1_end_i;
      end
      2'd2: begin
        w_sel_val  = slv2_val_i;
        w_sel_data = slv2_data_i;
        w_sel_end  = slv2_end_i;
      end
      default: begin
        w_sel_val  = slv0_val_i;
        w_sel_data = slv0_data_i;
        w_sel_end  = slv0_end_i;
      end
    endcase
  end

  assign w_cnt_last = (r_cnt == (r_len - 6'd1));
  // A packet terminates on the slave's end marker or on reaching its length,
  // whichever comes first.
  assign w_term     = w_sel_end | w_cnt_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 2'd2;
      r_id    <= 2'd0;
      r_len   <= 6'd0;
      r_cnt   <= 6'd0;
      r_ack   <= 3'b000;
      r_val   <= 1'b0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack   <= 3'b000;
      r_val   <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fmt_rdy_i && w_any_req) begin
            r_id    <= w_win;
            r_len   <= w_win_len;
            r_ack   <= 3'b001 << w_win;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_last  <= r_id;
          r_cnt   <= 6'd0;
          r_state <= XFER;
        end
        XFER: begin
          if (w_sel_val) begin
            r_val   <= 1'b1;
            r_data  <= w_sel_data;
            r_start <= (r_cnt == 6'd0);
            r_end   <= w_term;
            // Early end (end without last count) or missing end (last count
            // without end) are both framing errors.
            r_err   <= w_sel_end ^ w_cnt_last;
            r_cnt   <= r_cnt + 6'd1;
            if (w_term) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a2s0_ack_o  = r_ack[0];
  assign a2s1_ack_o  = r_ack[1];
  assign a2s2_ack_o  = r_ack[2];
  assign arb_val_o   = r_val;
  assign arb_data_o  = r_data;
  assign arb_start_o = r_start;
  assign arb_end_o   = r_end;
  assign arb_id_o    = r_id;
  assign arb_len_o   = r_len;
  assign arb_busy_o  = (r_state == ACK) || (r_state == XFER);
  assign arb_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mcdf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcdf_arbiter
// Purpose  : Directed self-checking bench for mcdf_arbiter: grant latency,
//            priority and round-robin order, formatter back-pressure, framing
//            errors and mid-packet reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_mcdf_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          req  [3];
  logic          val  [3];
  logic [DW-1:0] data [3];
  logic          eop  [3];
  logic [1:0]    prio [3];
  logic [2:0]    pkl  [3];
  logic          fmt_rdy;

  logic          ack0, ack1, ack2;
  logic          o_val, o_start, o_end, o_busy, o_err;
  logic [DW-1:0] o_data;
  logic [1:0]    o_id;
  logic [5:0]    o_len;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  mcdf_arbiter #(.DW(DW), .NSLV(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv0_req_i   (req[0]),
    .slv1_req_i   (req[1]),
    .slv2_req_i   (req[2]),
    .slv0_val_i   (val[0]),
    .slv1_val_i   (val[1]),
    .slv2_val_i   (val[2]),
    .slv0_data_i  (data[0]),
    .slv1_data_i  (data[1]),
    .slv2_data_i  (data[2]),
    .slv0_end_i   (eop[0]),
    .slv1_end_i   (eop[1]),
    .slv2_end_i   (eop[2]),
    .slv0_prio_i  (prio[0]),
    .slv1_prio_i  (prio[1]),
    .slv2_prio_i  (prio[2]),
    .slv0_pkglen_i(pkl[0]),
    .slv1_pkglen_i(pkl[1]),
    .slv2_pkglen_i(pkl[2]),
    .fmt_rdy_i    (fmt_rdy),
    .a2s0_ack_o   (ack0),
    .a2s1_ack_o   (ack1),
    .a2s2_ack_o   (ack2),
    .arb_val_o    (o_val),
    .arb_data_o   (o_data),
    .arb_start_o  (o_start),
    .arb_end_o    (o_end),
    .arb_id_o     (o_id),
    .arb_len_o    (o_len),
    .arb_busy_o   (o_busy),
    .arb_err_o    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] acks();
    return {ack2, ack1, ack0};
  endfunction

  // Check the grant cycle: one-hot ack, latched id/len, busy.
  task automatic chk_grant(input string tag, input int s, input int len);
    chk({tag, "_ack"},  64'(acks()), 64'(3'b001 << s));
    chk({tag, "_id"},   64'(o_id), 64'(s));
    chk({tag, "_len"},  64'(o_len), 64'(len));
    chk({tag, "_busy"}, 64'(o_busy), 64'd1);
  endtask

  // Step past ACK, then stream n words from slave s with end on word end_at
  // (-1 = never). The n-th word must close the packet with end=1 and the
  // given error flag; earlier words carry no end and no error.
  task automatic xfer(input string tag, input int s, input int n, input int end_at,
                      input logic [DW-1:0] base, input logic exp_err);
    step();
    chk({tag, "_xfer_busy"}, 64'(o_busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      val[s]  = 1'b1;
      data[s] = base + DW'(i);
      eop[s]  = (i == end_at);
      step();
      chk({tag, "_val"},   64'(o_val), 64'd1);
      chk({tag, "_data"},  64'(o_data), 64'(base + DW'(i)));
      chk({tag, "_start"}, 64'(o_start), 64'(i == 0));
      chk({tag, "_end"},   64'(o_end), 64'(i == n - 1));
      chk({tag, "_err"},   64'(o_err), (i == n - 1) ? 64'(exp_err) : 64'd0);
      chk({tag, "_noack"}, 64'(acks()), 64'd0);
    end
    chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    val[s] = 1'b0;
    eop[s] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fmt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; val[i] = 1'b0; data[i] = '0; eop[i] = 1'b0;
      prio[i] = 2'd0; pkl[i] = 3'd0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_ack",  64'(acks()), 64'd0);
    chk("rst_val",  64'(o_val), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_id",   64'(o_id), 64'd0);
    chk("rst_len",  64'(o_len), 64'd0);
    chk("rst_err",  64'(o_err), 64'd0);

    // Single slave1 packet of 4 words, ack one cycle after request seen
    fmt_rdy = 1'b1;
    prio[1] = 2'd0; pkl[1] = 3'd0; req[1] = 1'b1;
    step();
    chk_grant("t1", 1, 4);
    req[1] = 1'b0;
    xfer("t1", 1, 4, 3, 32'hA000_0001, 1'b0);

    // Fresh start: equal priorities held high -> 0,1,2,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prio[i] = 2'd1; pkl[i] = 3'd0; req[i] = 1'b1;
    end
    step();
    chk_grant("rr0", 0, 4);
    xfer("rr0", 0, 4, 3, 32'h1000_0000, 1'b0);
    step();
    chk_grant("rr1", 1, 4);
    xfer("rr1", 1, 4, 3, 32'h1100_0000, 1'b0);
    step();
    chk_grant("rr2", 2, 4);
    xfer("rr2", 2, 4, 3, 32'h1200_0000, 1'b0);
    step();
    chk_grant("rr3", 0, 4);
    xfer("rr3", 0, 4, 3, 32'h1300_0000, 1'b0);
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    step();
    chk("rr_quiet", 64'(acks()), 64'd0);

    // Priorities 2,0,1 -> slave1, slave2, slave0
    prio[0] = 2'd2; prio[1] = 2'd0; prio[2] = 2'd1;
    for (int i = 0; i < 3; i++) req[i] = 1'b1;
    step();
    chk_grant("pr1", 1, 4);
    req[1] = 1'b0;
    xfer("pr1", 1, 4, 3, 32'h2100_0000, 1'b0);
    step();
    chk_grant("pr2", 2, 4);
    req[2] = 1'b0;
    xfer("pr2", 2, 4, 3, 32'h2200_0000, 1'b0);
    step();
    chk_grant("pr0", 0, 4);
    req[0] = 1'b0;
    xfer("pr0", 0, 4, 3, 32'h2000_0000, 1'b0);

    // Formatter not ready: no grant for 10 cycles, then grant next cycle
    fmt_rdy = 1'b0;
    req[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rdy0_ack",  64'(acks()), 64'd0);
      chk("rdy0_busy", 64'(o_busy), 64'd0);
    end
    fmt_rdy = 1'b1;
    step();
    chk_grant("rdy1", 0, 4);
    req[0] = 1'b0;
    xfer("rdy1", 0, 4, 3, 32'h3000_0000, 1'b0);

    // Slave2, 8-word packet: end on word 3 -> early-end error
    pkl[2] = 3'd1; req[2] = 1'b1;
    step();
    chk_grant("early", 2, 8);
    req[2] = 1'b0;
    xfer("early", 2, 3, 2, 32'h4000_0000, 1'b1);

    // Slave2, 8-word packet, no end -> forced end and error on word 8
    req[2] = 1'b1;
    step();
    chk_grant("miss", 2, 8);
    req[2] = 1'b0;
    xfer("miss", 2, 8, -1, 32'h5000_0000, 1'b1);

    // Length code bit 2 ignored: code 5 behaves as code 1 (8 words)
    pkl[1] = 3'd5; prio[1] = 2'd0; req[1] = 1'b1;
    step();
    chk_grant("bit2", 1, 8);
    req[1] = 1'b0;
    xfer("bit2", 1, 8, 7, 32'h5500_0000, 1'b0);

    // Reset on word 2 of a 16-word slave0 packet
    pkl[0] = 3'd2; prio[0] = 2'd0; req[0] = 1'b1;
    step();
    chk_grant("mrst", 0, 16);
    req[0] = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      val[0] = 1'b1; data[0] = 32'h6000_0000 + DW'(i);
      step();
      chk("mrst_pre_val", 64'(o_val), 64'd1);
    end
    val[0] = 1'b1; data[0] = 32'h6000_0002;
    rst = 1'b1;
    step();
    rst = 1'b0;
    val[0] = 1'b0;
    chk("mrst_val",   64'(o_val), 64'd0);
    chk("mrst_data",  64'(o_data), 64'd0);
    chk("mrst_start", 64'(o_start), 64'd0);
    chk("mrst_end",   64'(o_end), 64'd0);
    chk("mrst_busy",  64'(o_busy), 64'd0);
    chk("mrst_id",    64'(o_id), 64'd0);
    chk("mrst_len",   64'(o_len), 64'd0);
    chk("mrst_ack",   64'(acks()), 64'd0);
    step();
    chk("mrst_nopart", 64'(o_val), 64'd0);

    // After reset the pointer is 2, so slave0 wins a tie with slave1
    prio[0] = 2'd1; prio[1] = 2'd1; pkl[0] = 3'd0; pkl[1] = 3'd0;
    req[0] = 1'b1; req[1] = 1'b1;
    step();
    chk_grant("tie", 0, 4);
    req[0] = 1'b0; req[1] = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Shares the single formatter datapath between three slave_FIFO channels, one packet at a time.
- Picks a winner among slaves requesting with slvx_req. The pick is by per-slave priority, with round-robin among equal priorities.
- Issues the one-cycle a2sx_ack to the winner and forwards its packet words to the formatter as a registered stream.
- Counts words against the winner's packet length and flags framing errors.

Parameters:
- DW, 32, data word width.
- NSLV, 3, number of slave channels (fixed at 3; ids 0..2).

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- slv0_req_i, slv1_req_i, slv2_req_i  input  1 each  slave has a complete packet ready.
- slv0_val_i, slv1_val_i, slv2_val_i  input  1 each  slave data word valid.
- slv0_data_i, slv1_data_i, slv2_data_i  input  DW each  slave data word.
- slv0_end_i, slv1_end_i, slv2_end_i  input  1 each  last word of the packet.
- slv0_prio_i, slv1_prio_i, slv2_prio_i  input  2 each  priority; 0 is highest.
- slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i  input  3 each  packet length code.
- fmt_rdy_i  input  1  formatter can accept a whole packet.
- a2s0_ack_o, a2s1_ack_o, a2s2_ack_o  output  1 each  one-cycle grant pulse to a slave.
- arb_val_o  output  1  output word valid.
- arb_data_o  output  DW  output word.
- arb_start_o  output  1  first word of packet (qualified by arb_val_o).
- arb_end_o  output  1  last word of packet (qualified by arb_val_o).
- arb_id_o  output  2  source slave of current packet.
- arb_len_o  output  6  packet length in words, held during the packet.
- arb_busy_o  output  1  packet in flight (ACK or XFER state).
- arb_err_o  output  1  one-cycle framing-error pulse.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous, active-high.
- Reset values:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Last-grant pointer is set to 2, so slave 0 wins the first tie.
  - Word counter is 0.
  - Reset in any state (including mid-XFER) takes effect on the next edge. No partial words are emitted afterwards.
- Length code (bits [1:0] used; bit 2 ignored):
  - 0 -> 4 words
  - 1 -> 8 words
  - 2 -> 16 words
  - 3 -> 32 words
- FSM states: IDLE, ACK, XFER.
- IDLE:
  - Leaves IDLE only when fmt_rdy_i=1 and any req_i=1.
  - Winner is the lowest prio_i value among requesters.
  - Ties go round-robin: start searching from (last_grant+1) mod 3.
  - On the edge: latch winner id and its pkglen, go to ACK.
- ACK:
  - Exactly one a2sx_ack_o is high, for one cycle.
  - last_grant is updated to the winner.
  - Counter cleared.
  - Unconditionally go to XFER.
- XFER:
  - Only the winner's val/data/end are used. Other slaves' inputs are ignored.
  - Each winner val_i=1 cycle: register data into arb_data_o and set arb_val_o=1 on the next cycle.
  - arb_start_o=1 when counter==0. arb_end_o = winner end_i. Counter increments.
  - Gaps (val_i=0) are allowed; arb_val_o=0 on those cycles.
  - Normal end: end_i arrives with counter==len-1. Go to IDLE. The new arbitration may run in that same IDLE cycle.
  - Error, end too early: end_i arrives with counter<len-1. Pulse arb_err_o together with that output word, then go to IDLE.
  - Error, end missing: counter reaches len-1 without end_i. Force arb_end_o=1 on that word, pulse arb_err_o, go to IDLE.
- Latency:
  - Request seen in IDLE -> ack 1 cycle later.
  - Slave word -> arb output 1 cycle later.
- arb_busy_o=1 in ACK and XFER.
- arb_id_o and arb_len_o are updated on entering ACK and held until the next grant.
- Requests arriving during ACK/XFER are not lost; they are evaluated in the next IDLE. req_i is level and stays high until the slave is acked.
- fmt_rdy_i is sampled only in IDLE. Dropping it mid-packet does not stall.

Test Plan:
- Slave1 req, prio=0, pkglen=0, words A1..A4 with no gaps -> a2s1_ack_o one cycle after req sampled; 4 arb_val_o cycles; id=1, len=4; start on A1, end on A4; err=0.
- All three req, equal prio 1, pkglen=0, held high -> grant order 0,1,2,0; each packet 4 words; no ack while busy.
- Prios 2,0,1 all requesting -> grant order slave1, slave2, slave0.
- fmt_rdy_i=0 with slave0 req for 10 cycles -> no ack, busy=0; fmt_rdy_i->1 -> a2s0_ack_o next cycle.
- Slave2 pkglen=1 (8 words) with end on word 3 -> arb_err_o pulses with word 3, FSM back to IDLE. Separately, no end by word 8 -> forced arb_end_o and arb_err_o on word 8.
- rst_i asserted on word 2 of a 16-word packet -> next cycle all outputs 0, busy=0; slave0 wins the next tie.
